vtile_mem_sched: RTL and testbench
==================================

# vtile_mem_sched

Write-port scheduler for the vector tile register-file memory. It sits between up to NUM_REQ CGRA network requesters and the memory's single write port. It arbitrates round-robin, buffers the granted vector, and drives the memory write handshake (write_en held until write_ack). On request it then pulses the memory's on_off input so the vector FU executes on the freshly written data, guaranteeing that write_en and on_off never overlap.

## Interface
- WIDTH, 16, element width in bits
- NUM_INPUTS, 8, highest element index; vectors carry NUM_INPUTS+1 elements
- NUM_REQ, 4, number of network requesters (2..8)
- EXEC_CYCLES, 1, cycles on_off is held high per execution (1..15)
- ACK_TIMEOUT, 15, max WRITE cycles before abort (used only with the timeout macro)
- clk  input  1  sole clock, rising edge
- reset  input  1  asynchronous, active-low reset
- req_valid  input  NUM_REQ  per-requester write request
- req_exec  input  NUM_REQ  per-requester "execute after write" flag, qualified by req_valid
- req_data  input  NUM_REQ x (NUM_INPUTS+1) x WIDTH  per-requester vector
- req_ready  output  NUM_REQ  one-hot accept; transfer occurs when req_valid[i] && req_ready[i]
- mem_write_en  output  1  to memory write_en
- mem_w_data  output  (NUM_INPUTS+1) x WIDTH  to memory w_data_in, from the internal buffer
- mem_write_rdy  input  1  from memory write_rdy
- mem_write_ack  input  1  from memory write_ack
- mem_on_off  output  1  to memory on_off
- done_valid  output  1  one-cycle completion pulse
- done_id  output  $clog2(NUM_REQ)  requester index of the completed transaction
- done_err  output  1  completion was a timeout abort (0 when the macro is off)
- busy  output  1  state != IDLE

## Operation
- FSM states are IDLE, WRITE and EXEC. All outputs are registered except req_ready.
- IDLE
  - req_ready[i] = mem_write_rdy && i is the first requester with req_valid set, searching from rr_ptr upward and wrapping.
  - On accept: capture req_data[i] into the buffer, req_exec[i] into exec_flag, and i into cur_id. Set rr_ptr to (i+1) mod NUM_REQ. Go to WRITE.
- WRITE
  - mem_write_en = 1 and mem_w_data = buffer, held stable.
  - On the edge where mem_write_ack is 1, go to EXEC if exec_flag is set, otherwise go to IDLE and pulse done.
- EXEC
  - mem_on_off = 1 for exactly EXEC_CYCLES cycles, counted by a 4-bit counter.
  - Then go to IDLE and pulse done.
- done_valid, done_id and done_err are asserted for one cycle, on the first IDLE cycle after completion.
- The buffer holds its contents after a transaction. mem_w_data is stable while mem_write_en = 1.
- If no requester is valid, or mem_write_rdy = 0, the block stays in IDLE and req_ready = 0.
- Simultaneous requests: exactly one grant per transaction, in round-robin order. A requester holding req_valid high is served within NUM_REQ transactions.
- A request arriving while busy waits. req_ready stays 0 outside IDLE.
- Reset (reset = 0): immediate, at any time including mid-WRITE or mid-EXEC.
  - Outputs: mem_write_en = 0, mem_on_off = 0, req_ready = 0, done_valid = 0, done_id = 0, done_err = 0, busy = 0.
  - Internal: state = IDLE, rr_ptr = 0, buffer = 0, counters = 0.

## Timing
- Accept edge to mem_write_en = 1: 1 cycle.
- mem_write_ack sampled high at edge T:
  - mem_write_en = 0 from T.
  - mem_on_off = 1 from T, in the same cycle write_en drops. This is legal because the memory gates on_off with !write_en.
  - If the memory ever sees both high, on_off is masked; the scheduler never produces that overlap.
- Earliest next accept is 2 cycles after the last output goes low, because the memory's write_rdy is registered and the FSM adds one IDLE cycle.
- Minimum transaction length, accept to done_valid: 3 cycles without exec; 3+EXEC_CYCLES cycles with exec.

## Configuration
- VTILE_SCHED_TIMEOUT_EN defined:
  - An 8-bit counter runs in WRITE.
  - If mem_write_ack has not arrived after ACK_TIMEOUT cycles in WRITE, the FSM drops mem_write_en, skips EXEC and goes to IDLE, pulsing done_valid with done_err = 1.
- Undefined: no counter; WRITE waits indefinitely; done_err is tied to 0.

## Structure
- Package vtile_pkg holds:
  - the state enum typedef (IDLE, WRITE, EXEC)
  - the vector typedef, a logic [WIDTH-1:0] array [NUM_INPUTS:0]
  - default constants for WIDTH, NUM_INPUTS and NUM_REQ
- One sub-module: rr_arbiter (parameter N; inputs req, ptr, en; output one-hot gnt). It is purely combinational and reused by other tile schedulers.

## Test plan
- Single write, no exec:
  - Stimulus: after reset release, req_valid = 4'b0010, req_exec = 0, vector elements 0x0100..0x0108.
  - Required: req_ready[1] pulses; mem_write_en is 1 on the next cycle with matching data; after ack, done_valid with done_id = 1 and mem_on_off never high.
- Write plus exec, EXEC_CYCLES = 3:
  - Required: mem_on_off is high for exactly 3 cycles, starting on the cycle mem_write_en falls.
  - Required: no cycle has both outputs high.
- Round-robin fairness:
  - Stimulus: all 4 requesters valid continuously.
  - Required: grant order 0, 1, 2, 3, 0; each requester receives exactly 2 of 8 transactions.
- Backpressure:
  - Stimulus: hold mem_write_rdy = 0 for 5 cycles with req_valid = 4'b0001.
  - Required: req_ready stays 0 and busy = 0; accept occurs in the first cycle mem_write_rdy = 1.
- Reset mid-EXEC:
  - Stimulus: drive reset = 0 asynchronously during the 2nd on_off cycle.
  - Required: mem_on_off = 0 immediately; after release, the first grant goes to requester 0.
- Timeout (macro defined, ACK_TIMEOUT = 15):
  - Stimulus: never assert mem_write_ack.
  - Required: mem_write_en falls after 15 WRITE cycles; done_valid = 1 with done_err = 1; mem_on_off stays 0 even with req_exec = 1.

Source files
------------

// File: rtl/vtile_pkg.sv
// Shared types and defaults for the vector tile schedulers.
package vtile_pkg;

    localparam int unsigned DefWidth     = 16;
    localparam int unsigned DefNumInputs = 8;
    localparam int unsigned DefNumReq    = 4;

    typedef enum logic [1:0] {
        StIdle,
        StWrite,
        StExec
    } sched_state_e;

    typedef logic [DefWidth-1:0] vector_t [DefNumInputs:0];

    // Flattened bit width of one vector of num_inputs+1 elements.
    function automatic int unsigned vec_bits(input int unsigned width,
                                             input int unsigned num_inputs);
        return width * (num_inputs + 1);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: one-hot grant to the first set request
// found searching upward from ptr and wrapping. No grant when en is low.
module rr_arbiter #(
    parameter int unsigned N = 4
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] ptr,
    input  logic                 en,
    output logic [N-1:0]         gnt
);

    localparam int unsigned PtrW = $clog2(N);

    logic            found;
    logic [PtrW-1:0] idx;

    // Rotating priority search starting at ptr.
    always_comb begin
        gnt   = '0;
        found = 1'b0;
        idx   = '0;
        for (int k = 0; k < int'(N); k++) begin
            idx = PtrW'((int'(ptr) + k) % int'(N));
            if (en && !found && req[idx]) begin
                gnt[idx] = 1'b1;
                found    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/vtile_mem_sched.sv
// Write-port scheduler for the vector tile register-file memory.
// Arbitrates NUM_REQ requesters round-robin, buffers the granted vector, holds
// mem_write_en until mem_write_ack, then optionally pulses mem_on_off for
// EXEC_CYCLES cycles. write_en and on_off are never high together.
// Optional feature: define VTILE_SCHED_TIMEOUT_EN to abort a WRITE that sees no
// ack within ACK_TIMEOUT cycles (done_err = 1).
module vtile_mem_sched
    import vtile_pkg::*;
#(
    parameter int unsigned WIDTH       = DefWidth,
    parameter int unsigned NUM_INPUTS  = DefNumInputs,
    parameter int unsigned NUM_REQ     = DefNumReq,
    parameter int unsigned EXEC_CYCLES = 1,
    parameter int unsigned ACK_TIMEOUT = 15
) (
    input  logic                                      clk,
    input  logic                                      reset,
    input  logic [NUM_REQ-1:0]                        req_valid,
    input  logic [NUM_REQ-1:0]                        req_exec,
    input  logic [NUM_REQ*(NUM_INPUTS+1)*WIDTH-1:0]   req_data,
    output logic [NUM_REQ-1:0]                        req_ready,
    output logic                                      mem_write_en,
    output logic [(NUM_INPUTS+1)*WIDTH-1:0]           mem_w_data,
    input  logic                                      mem_write_rdy,
    input  logic                                      mem_write_ack,
    output logic                                      mem_on_off,
    output logic                                      done_valid,
    output logic [$clog2(NUM_REQ)-1:0]                done_id,
    output logic                                      done_err,
    output logic                                      busy
);

    localparam int unsigned IdW      = $clog2(NUM_REQ);
    localparam int unsigned VecW     = vec_bits(WIDTH, NUM_INPUTS);
    localparam logic [3:0]  ExecLast = 4'(EXEC_CYCLES - 1);

    sched_state_e    state_q, state_d;
    logic [IdW-1:0]  rr_ptr_q, rr_ptr_d;
    logic [IdW-1:0]  cur_id_q, cur_id_d;
    logic            exec_flag_q, exec_flag_d;
    logic [VecW-1:0] buf_q, buf_d;
    logic [3:0]      exec_cnt_q, exec_cnt_d;
    logic            done_d, err_d;

    logic            mem_write_en_q, mem_on_off_q, busy_q;
    logic            done_valid_q, done_err_q;
    logic [IdW-1:0]  done_id_q;

    logic [NUM_REQ-1:0] gnt;
    logic               grant_any;
    logic [IdW-1:0]     grant_id;
    logic [VecW-1:0]    grant_vec;
    logic               grant_exec;

`ifdef VTILE_SCHED_TIMEOUT_EN
    localparam logic [7:0] AckLast = 8'(ACK_TIMEOUT - 1);
    logic [7:0] to_cnt_q, to_cnt_d;
`else
    logic unused_ack_timeout;
    assign unused_ack_timeout = ^ACK_TIMEOUT;
`endif

    // reset is folded in so req_ready is 0 while reset is asserted.
    rr_arbiter #(
        .N (NUM_REQ)
    ) u_arb (
        .req (req_valid),
        .ptr (rr_ptr_q),
        .en  ((state_q == StIdle) && mem_write_rdy && reset),
        .gnt (gnt)
    );

    assign req_ready = gnt;
    assign grant_any = |gnt;

    // Encode the one-hot grant and select the granted requester's payload.
    always_comb begin
        grant_id   = '0;
        grant_vec  = '0;
        grant_exec = 1'b0;
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            if (gnt[i]) begin
                grant_id   = IdW'(i);
                grant_vec  = req_data[i*VecW +: VecW];
                grant_exec = req_exec[i];
            end
        end
    end

    // Next-state logic for the IDLE/WRITE/EXEC controller.
    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        cur_id_d    = cur_id_q;
        exec_flag_d = exec_flag_q;
        buf_d       = buf_q;
        exec_cnt_d  = '0;
        done_d      = 1'b0;
        err_d       = 1'b0;
`ifdef VTILE_SCHED_TIMEOUT_EN
        to_cnt_d    = '0;
`endif
        unique case (state_q)
            StIdle: begin
                if (grant_any) begin
                    buf_d       = grant_vec;
                    exec_flag_d = grant_exec;
                    cur_id_d    = grant_id;
                    rr_ptr_d    = (grant_id == IdW'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;
                    state_d     = StWrite;
                end
            end
            StWrite: begin
                if (mem_write_ack) begin
                    if (exec_flag_q) begin
                        state_d = StExec;
                    end else begin
                        state_d = StIdle;
                        done_d  = 1'b1;
                    end
                end
`ifdef VTILE_SCHED_TIMEOUT_EN
                else if (to_cnt_q == AckLast) begin
                    // Abort: EXEC is skipped even if exec_flag is set.
                    state_d = StIdle;
                    done_d  = 1'b1;
                    err_d   = 1'b1;
                end else begin
                    to_cnt_d = to_cnt_q + 8'd1;
                end
`endif
            end
            StExec: begin
                if (exec_cnt_q == ExecLast) begin
                    state_d = StIdle;
                    done_d  = 1'b1;
                end else begin
                    exec_cnt_d = exec_cnt_q + 4'd1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State, datapath and registered outputs; outputs decode the next state so
    // write_en falls and on_off rises on the same edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q        <= StIdle;
            rr_ptr_q       <= '0;
            cur_id_q       <= '0;
            exec_flag_q    <= 1'b0;
            buf_q          <= '0;
            exec_cnt_q     <= '0;
            mem_write_en_q <= 1'b0;
            mem_on_off_q   <= 1'b0;
            busy_q         <= 1'b0;
            done_valid_q   <= 1'b0;
            done_id_q      <= '0;
            done_err_q     <= 1'b0;
`ifdef VTILE_SCHED_TIMEOUT_EN
            to_cnt_q       <= '0;
`endif
        end else begin
            state_q        <= state_d;
            rr_ptr_q       <= rr_ptr_d;
            cur_id_q       <= cur_id_d;
            exec_flag_q    <= exec_flag_d;
            buf_q          <= buf_d;
            exec_cnt_q     <= exec_cnt_d;
            mem_write_en_q <= (state_d == StWrite);
            mem_on_off_q   <= (state_d == StExec);
            busy_q         <= (state_d != StIdle);
            done_valid_q   <= done_d;
            done_id_q      <= done_d ? cur_id_q : '0;
            done_err_q     <= err_d;
`ifdef VTILE_SCHED_TIMEOUT_EN
            to_cnt_q       <= to_cnt_d;
`endif
        end
    end

    assign mem_write_en = mem_write_en_q;
    assign mem_w_data   = buf_q;
    assign mem_on_off   = mem_on_off_q;
    assign busy         = busy_q;
    assign done_valid   = done_valid_q;
    assign done_id      = done_id_q;
    assign done_err     = done_err_q;

endmodule

// File: tb/tb_vtile_mem_sched.sv
// Directed bench for vtile_mem_sched with a scoreboard of expected
// transactions. The timeout section runs only when VTILE_SCHED_TIMEOUT_EN is
// defined.
module tb_vtile_mem_sched;

    localparam int W  = 16;
    localparam int NI = 8;
    localparam int NR = 4;
    localparam int EC = 3;
    localparam int AT = 15;
    localparam int VW = W * (NI + 1);

    logic              clk = 1'b0;
    logic              reset;
    logic [NR-1:0]     req_valid, req_exec, req_ready;
    logic [NR*VW-1:0]  req_data;
    logic              mem_write_en, mem_write_rdy, mem_write_ack, mem_on_off;
    logic [VW-1:0]     mem_w_data;
    logic              done_valid, done_err, busy;
    logic [1:0]        done_id;
    logic              auto_ack;

    typedef struct packed {
        logic [1:0]    id;
        logic [VW-1:0] data;
        logic          exec;
    } exp_t;

    exp_t        sb[$];
    int          vectors = 0;
    int          miscompares = 0;
    int          grants[NR];
    logic [15:0] bases[NR];
    logic [1:0]  model_ptr;
    bit          overlap_seen = 1'b0;

    always #5 clk = ~clk;

    vtile_mem_sched #(
        .WIDTH       (W),
        .NUM_INPUTS  (NI),
        .NUM_REQ     (NR),
        .EXEC_CYCLES (EC),
        .ACK_TIMEOUT (AT)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .req_valid     (req_valid),
        .req_exec      (req_exec),
        .req_data      (req_data),
        .req_ready     (req_ready),
        .mem_write_en  (mem_write_en),
        .mem_w_data    (mem_w_data),
        .mem_write_rdy (mem_write_rdy),
        .mem_write_ack (mem_write_ack),
        .mem_on_off    (mem_on_off),
        .done_valid    (done_valid),
        .done_id       (done_id),
        .done_err      (done_err),
        .busy          (busy)
    );

    // Memory model: registered single-cycle ack one cycle after write_en is seen.
    always @(posedge clk or negedge reset) begin
        if (!reset) mem_write_ack <= 1'b0;
        else        mem_write_ack <= auto_ack && mem_write_en && !mem_write_ack;
    end

    // Watch for write_en/on_off overlap throughout the run.
    always @(negedge clk) begin
        if (mem_write_en && mem_on_off) overlap_seen = 1'b1;
    end

    task automatic check(input string tag, input logic [VW-1:0] obs, input logic [VW-1:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [VW-1:0] make_vec(input logic [15:0] base);
        logic [VW-1:0] v;
        for (int e = 0; e <= NI; e++) v[e*W +: W] = base + 16'(e);
        return v;
    endfunction

    function automatic int model_pick(input logic [NR-1:0] v, input logic [1:0] p);
        for (int k = 0; k < NR; k++) begin
            if (v[(int'(p) + k) % NR]) return (int'(p) + k) % NR;
        end
        return 0;
    endfunction

    task automatic drive_req(input int id, input logic [15:0] base, input logic ex);
        req_valid[id] = 1'b1;
        req_exec[id]  = ex;
        bases[id]     = base;
        req_data[id*VW +: VW] = make_vec(base);
    endtask

    // Push the model's prediction for the next grant given current stimulus.
    task automatic push_expected();
        int id;
        id = model_pick(req_valid, model_ptr);
        sb.push_back('{id: 2'(id), data: make_vec(bases[id]), exec: req_exec[id]});
        model_ptr = 2'((id + 1) % NR);
    endtask

    // Wait for an accept, then follow one transaction to its done pulse.
    // Returns at the negedge where done_valid is seen.
    task automatic serve(input bit drop, output int waited);
        exp_t e;
        int   on_cnt;
        bit   got, prev_we, first_ok, seen_on, stable;
        e = sb.pop_front();
        got = 1'b0;
        waited = 0;
        for (int c = 0; c < 20; c++) begin
            #1;
            if (|(req_valid & req_ready)) begin
                got = 1'b1;
                break;
            end
            waited++;
            @(negedge clk);
        end
        check("accept_seen", VW'(got), VW'(1));
        if (!got) return;
        check("grant", VW'(req_ready), VW'(4'b0001 << e.id));
        grants[e.id]++;
        @(negedge clk);
        if (drop) req_valid = '0;
        check("write_en_rise", VW'(mem_write_en), VW'(1));
        check("w_data", mem_w_data, e.data);
        on_cnt = 0; prev_we = 1'b1; first_ok = 1'b0; seen_on = 1'b0; stable = 1'b1; got = 1'b0;
        for (int c = 0; c < 40; c++) begin
            if (done_valid) begin
                got = 1'b1;
                break;
            end
            if (mem_write_en && mem_w_data !== e.data) stable = 1'b0;
            if (mem_on_off) begin
                if (!seen_on) first_ok = prev_we && !mem_write_en;
                seen_on = 1'b1;
                on_cnt++;
            end
            prev_we = mem_write_en;
            @(negedge clk);
        end
        check("done_seen", VW'(got), VW'(1));
        check("done_id", VW'(done_id), VW'(e.id));
        check("done_err", VW'(done_err), VW'(0));
        check("on_off_cycles", VW'(on_cnt), VW'(e.exec ? EC : 0));
        check("w_data_stable", VW'(stable), VW'(1));
        if (e.exec) check("on_off_starts_at_we_fall", VW'(first_ok), VW'(1));
    endtask

    initial begin
        int  w;
        bit  got;
        reset = 1'b0;
        req_valid = '0; req_exec = '0; req_data = '0;
        mem_write_rdy = 1'b1;
        auto_ack = 1'b1;
        model_ptr = '0;
        for (int i = 0; i < NR; i++) begin grants[i] = 0; bases[i] = '0; end

        // Reset state, with requests pending to show req_ready is held off.
        req_valid = 4'b1111;
        repeat (2) @(negedge clk);
        #1;
        check("rst_req_ready", VW'(req_ready), VW'(0));
        check("rst_write_en", VW'(mem_write_en), VW'(0));
        check("rst_on_off", VW'(mem_on_off), VW'(0));
        check("rst_done_valid", VW'(done_valid), VW'(0));
        check("rst_done_id", VW'(done_id), VW'(0));
        check("rst_done_err", VW'(done_err), VW'(0));
        check("rst_busy", VW'(busy), VW'(0));
        check("rst_w_data", mem_w_data, '0);
        @(negedge clk);
        req_valid = '0;
        reset = 1'b1;

        // Single write, no exec, requester 1.
        @(negedge clk);
        drive_req(1, 16'h0100, 1'b0);
        push_expected();
        serve(1'b1, w);
        @(negedge clk);
        #1;
        check("done_one_cycle", VW'(done_valid), VW'(0));
        check("idle_busy", VW'(busy), VW'(0));
        check("buffer_holds", mem_w_data, make_vec(16'h0100));

        // Write plus exec, requester 2.
        @(negedge clk);
        drive_req(2, 16'h0200, 1'b1);
        push_expected();
        serve(1'b1, w);

        // Backpressure: write_rdy low for 5 cycles.
        @(negedge clk);
        mem_write_rdy = 1'b0;
        drive_req(0, 16'h0300, 1'b0);
        for (int c = 0; c < 5; c++) begin
            #1;
            check("bp_req_ready", VW'(req_ready), VW'(0));
            check("bp_busy", VW'(busy), VW'(0));
            @(negedge clk);
        end
        mem_write_rdy = 1'b1;
        push_expected();
        serve(1'b1, w);
        check("bp_accept_first_rdy", VW'(w), VW'(0));

        // Reset during the 2nd on_off cycle of an exec transaction.
        @(negedge clk);
        drive_req(3, 16'h0400, 1'b1);
        got = 1'b0;
        for (int c = 0; c < 20; c++) begin
            #1;
            if (|(req_valid & req_ready)) begin got = 1'b1; break; end
            @(negedge clk);
        end
        check("rx_accept_seen", VW'(got), VW'(1));
        check("rx_grant", VW'(req_ready), VW'(4'b0001 << model_pick(req_valid, model_ptr)));
        @(negedge clk);
        req_valid = '0;
        got = 1'b0;
        for (int c = 0; c < 20; c++) begin
            if (mem_on_off) begin got = 1'b1; break; end
            @(negedge clk);
        end
        check("rx_on_off_seen", VW'(got), VW'(1));
        @(negedge clk);
        #2 reset = 1'b0;
        #1;
        check("rx_on_off_cleared", VW'(mem_on_off), VW'(0));
        check("rx_write_en_cleared", VW'(mem_write_en), VW'(0));
        check("rx_busy_cleared", VW'(busy), VW'(0));
        check("rx_done_cleared", VW'(done_valid), VW'(0));
        model_ptr = '0;
        for (int i = 0; i < NR; i++) begin
            drive_req(i, 16'(16'h1000 * (i + 1)), 1'b0);
            grants[i] = 0;
        end
        @(negedge clk);
        reset = 1'b1;

        // Round-robin fairness: all requesters valid for 8 transactions.
        for (int t = 0; t < 8; t++) begin
            push_expected();
            serve(1'b0, w);
        end
        req_valid = '0;
        for (int i = 0; i < NR; i++) check("fair_count", VW'(grants[i]), VW'(2));
        @(negedge clk);

`ifdef VTILE_SCHED_TIMEOUT_EN
        // Timeout: memory never acks; exec must be skipped.
        begin
            int we_cnt;
            bit on_seen;
            auto_ack = 1'b0;
            @(negedge clk);
            drive_req(0, 16'h0500, 1'b1);
            got = 1'b0;
            for (int c = 0; c < 20; c++) begin
                #1;
                if (|(req_valid & req_ready)) begin got = 1'b1; break; end
                @(negedge clk);
            end
            check("to_accept_seen", VW'(got), VW'(1));
            @(negedge clk);
            req_valid = '0;
            we_cnt = 0;
            on_seen = 1'b0;
            for (int c = 0; c < 40; c++) begin
                if (!mem_write_en) break;
                if (mem_on_off) on_seen = 1'b1;
                we_cnt++;
                @(negedge clk);
            end
            check("to_write_cycles", VW'(we_cnt), VW'(AT));
            check("to_done_valid", VW'(done_valid), VW'(1));
            check("to_done_err", VW'(done_err), VW'(1));
            check("to_done_id", VW'(done_id), VW'(0));
            for (int c = 0; c < 4; c++) begin
                if (mem_on_off) on_seen = 1'b1;
                @(negedge clk);
            end
            check("to_no_exec", VW'(on_seen), VW'(0));
            auto_ack = 1'b1;
        end
`endif

        check("no_overlap", VW'(overlap_seen), VW'(0));
        check("scoreboard_empty", VW'(sb.size()), VW'(0));
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    // Global bound so the run always ends.
    initial begin
        #200000;
        $display("FAIL global_timeout: observed not finished, required finished");
        $fatal(1, "simulation time limit");
    end

endmodule
